// File: rtl/pwl_activation.sv
// Pipelined piecewise-linear activation (hard_sigmoid / hard_tanh / relu / bypass) with valid/ready flow control.
// Optional out_sat clamp flag is compiled in when PWL_SAT_FLAG_EN is defined.
module pwl_activation #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12,
  parameter int SLOPE  = 6554
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
`ifdef PWL_SAT_FLAG_EN
  output logic              out_sat,
`endif
  output logic [DATA_W-1:0] out_data
);

  localparam int PROD_W = 2 * DATA_W;

  localparam logic [1:0] MODE_HSIG  = 2'd0;
  localparam logic [1:0] MODE_HTANH = 2'd1;
  localparam logic [1:0] MODE_RELU  = 2'd2;

  localparam logic signed [DATA_W-1:0] ONE_X     = DATA_W'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0] NEG_ONE_X = -ONE_X;
  localparam logic signed [PROD_W-1:0] ONE_P     = PROD_W'(1 << FRAC_W);
  localparam logic signed [PROD_W-1:0] HALF_P    = PROD_W'(1 << (FRAC_W - 1));
  localparam logic signed [PROD_W-1:0] SLOPE_P   = PROD_W'(SLOPE);

  logic                     en;

  logic                     s1_vld_q, s1_vld_d;
  logic [1:0]               s1_mode_q, s1_mode_d;
  logic signed [DATA_W-1:0] s1_x_q, s1_x_d;

  logic                     s2_vld_q, s2_vld_d;
  logic [1:0]               s2_mode_q, s2_mode_d;
  logic signed [DATA_W-1:0] s2_x_q, s2_x_d;
  logic signed [PROD_W-1:0] s2_p_q, s2_p_d;

  logic                     out_vld_q, out_vld_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] sig_s;
  logic [DATA_W-1:0]        res;

  assign en      = !out_vld_q || out_rdy;
  assign in_rdy  = en;
  assign out_vld = out_vld_q;
  assign out_data = out_data_q;

  // Product is formed at double width; SLOPE is positive so the result never overflows.
  assign x_ext = $signed({{DATA_W{s1_x_q[DATA_W-1]}}, s1_x_q});
  assign sig_s = (s2_p_q >>> (DATA_W - 1)) + HALF_P;

  always_comb begin
    res = s2_x_q;
    case (s2_mode_q)
      MODE_HSIG: begin
        if (sig_s[PROD_W-1])    res = '0;
        else if (sig_s > ONE_P) res = ONE_X;
        else                    res = sig_s[DATA_W-1:0];
      end
      MODE_HTANH: begin
        if (s2_x_q < NEG_ONE_X)  res = NEG_ONE_X;
        else if (s2_x_q > ONE_X) res = ONE_X;
        else                     res = s2_x_q;
      end
      MODE_RELU: begin
        if (s2_x_q[DATA_W-1]) res = '0;
        else                  res = s2_x_q;
      end
      default: res = s2_x_q;
    endcase
  end

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_mode_d  = s1_mode_q;
    s1_x_d     = s1_x_q;
    s2_vld_d   = s2_vld_q;
    s2_mode_d  = s2_mode_q;
    s2_x_d     = s2_x_q;
    s2_p_d     = s2_p_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (en) begin
      s1_vld_d  = in_vld;
      s1_mode_d = in_mode;
      s1_x_d    = in_data;
      s2_vld_d  = s1_vld_q;
      s2_mode_d = s1_mode_q;
      s2_x_d    = s1_x_q;
      s2_p_d    = x_ext * SLOPE_P;
      out_vld_d = s2_vld_q;
      // Bubbles leave the last valid result on the output.
      if (s2_vld_q) out_data_d = res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_mode_q  <= '0;
      s1_x_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_mode_q  <= '0;
      s2_x_q     <= '0;
      s2_p_q     <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_mode_q  <= s1_mode_d;
      s1_x_q     <= s1_x_d;
      s2_vld_q   <= s2_vld_d;
      s2_mode_q  <= s2_mode_d;
      s2_x_q     <= s2_x_d;
      s2_p_q     <= s2_p_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef PWL_SAT_FLAG_EN
  logic res_sat;
  logic out_sat_q, out_sat_d;

  always_comb begin
    res_sat = 1'b0;
    case (s2_mode_q)
      MODE_HSIG:  res_sat = sig_s[PROD_W-1] || (sig_s > ONE_P);
      MODE_HTANH: res_sat = (s2_x_q < NEG_ONE_X) || (s2_x_q > ONE_X);
      MODE_RELU:  res_sat = s2_x_q[DATA_W-1];
      default:    res_sat = 1'b0;
    endcase
  end

  always_comb begin
    out_sat_d = out_sat_q;
    if (en && s2_vld_q) out_sat_d = res_sat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_sat_q <= 1'b0;
    else        out_sat_q <= out_sat_d;
  end

  assign out_sat = out_sat_q;
`endif

endmodule
